// File: rtl/arcade_ram_bridge.sv
// Arcade RAM bridge: turns each Arcade Card RAM access from the CPU into one
// request/ack transaction on the SDRAM port. The CPU is held in wait until the
// SDRAM acks. A watchdog forces completion if no ack arrives.
module arcade_ram_bridge #(
    parameter int unsigned AW      = 21,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          RAM_CS_N,
    input  logic [AW-1:0] RAM_A,
    input  logic          WR_N,
    input  logic          RD_N,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    output logic          RDY,
    output logic          ERR,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [7:0]    MEM_DOUT,
    input  logic [7:0]    MEM_DIN,
    input  logic          MEM_ACK
);

    localparam int unsigned    WDW     = 16;
    // Last watchdog value before the forced completion; the REQ phase lasts TIMEOUT cycles.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           acc;
    logic           old_acc;
    logic           start;
    logic [WDW-1:0] wd_cnt;

    // A new access is the leading edge of either strobe while the RAM window is selected.
    assign acc   = ~(RD_N & WR_N);
    assign start = acc & ~old_acc & ~RAM_CS_N;

    // Wait states begin in the same cycle the strobe edge is seen.
    assign RDY = ~(((state == IDLE) & start) | (state == REQ));

    // Access sequencer, watchdog and registered SDRAM/CPU outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            old_acc  <= 1'b0;
            wd_cnt   <= '0;
            DO       <= 8'hFF;
            ERR      <= 1'b0;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DOUT <= '0;
        end else begin
            old_acc <= acc;
            case (state)
                IDLE: begin
                    if (start) begin
                        MEM_ADDR <= RAM_A;
                        MEM_WE   <= ~WR_N;
                        MEM_DOUT <= DI;
                        wd_cnt   <= '0;
                        MEM_REQ  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Ack has priority over a watchdog expiry in the same cycle.
                    if (MEM_ACK) begin
                        if (!MEM_WE) begin
                            DO <= MEM_DIN;
                        end
                        MEM_REQ <= 1'b0;
                        state   <= DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        DO      <= 8'hFF;
                        ERR     <= 1'b1;
                        MEM_REQ <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                DONE: begin
                    // Wait for the CPU to release its strobe before accepting a new access.
                    if (!acc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arcade_ram_bridge.sv
// Self-checking bench for arcade_ram_bridge. Main instance (TIMEOUT=16) carries
// the scoreboarded SDRAM transactions; a second instance (TIMEOUT=4) covers the watchdog.
module tb_arcade_ram_bridge;

    localparam int unsigned AW = 21;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    dout;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1;
    logic          cs_n4 = 1'b1;
    logic [AW-1:0] ram_a = '0;
    logic          wr_n = 1'b1;
    logic          rd_n = 1'b1;
    logic [7:0]    di = 8'h00;
    logic [7:0]    mem_din = 8'h00;
    logic          mem_ack = 1'b0;
    logic          mem_ack4 = 1'b0;

    logic [7:0]    do_o, do4;
    logic          rdy, rdy4, err, err4, mem_req, mem_req4, mem_we, mem_we4;
    logic [AW-1:0] mem_addr, mem_addr4;
    logic [7:0]    mem_dout, mem_dout4;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic req_seen = 1'b0;
    logic [7:0] exp_do = 8'hFF;
    int   rl, rc, guard;

    always #5 clk = ~clk;

    arcade_ram_bridge #(.AW(AW), .TIMEOUT(16)) u_dut (
        .CLK(clk), .RST_N(rst_n), .RAM_CS_N(cs_n), .RAM_A(ram_a), .WR_N(wr_n), .RD_N(rd_n),
        .DI(di), .DO(do_o), .RDY(rdy), .ERR(err), .MEM_REQ(mem_req), .MEM_WE(mem_we),
        .MEM_ADDR(mem_addr), .MEM_DOUT(mem_dout), .MEM_DIN(mem_din), .MEM_ACK(mem_ack)
    );

    arcade_ram_bridge #(.AW(AW), .TIMEOUT(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .RAM_CS_N(cs_n4), .RAM_A(ram_a), .WR_N(wr_n), .RD_N(rd_n),
        .DI(di), .DO(do4), .RDY(rdy4), .ERR(err4), .MEM_REQ(mem_req4), .MEM_WE(mem_we4),
        .MEM_ADDR(mem_addr4), .MEM_DOUT(mem_dout4), .MEM_DIN(mem_din), .MEM_ACK(mem_ack4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic release_strobes();
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    // One CPU access on the selected instance; the SDRAM ack is given in REQ cycle ack_at
    // (0 = never) and the strobe is dropped in REQ cycle abort_at (0 = held).
    task automatic do_access(input bit sel, input bit we, input logic [AW-1:0] addr,
                             input logic [7:0] data, input int ack_at, input int abort_at,
                             input logic [7:0] din, output int rdy_low, output int reqc);
        bit   done;
        logic r, q;
        done    = 1'b0;
        rdy_low = 0;
        reqc    = 0;
        @(posedge clk); #1;
        ram_a = addr;
        di    = data;
        if (we) wr_n = 1'b0; else rd_n = 1'b0;
        if (!sel) begin
            exp_q.push_back('{we, addr, data});
            if (!we && ack_at > 0) exp_do = din;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            r = sel ? rdy4 : rdy;
            q = sel ? mem_req4 : mem_req;
            if (c == 0) chk("rdy_at_edge", 32'(r), 32'(0));
            if (q) reqc++;
            if (!r) rdy_low++;
            else if (rdy_low > 0) done = 1'b1;
            mem_din = din;
            if (sel) mem_ack4 = !done && q && (reqc == ack_at);
            else     mem_ack  = !done && q && (reqc == ack_at);
            if (abort_at > 0 && q && reqc == abort_at) release_strobes();
        end
        if (!done) chk("access_done", 32'(0), 32'(1));
    endtask

    // Scoreboard: every rising MEM_REQ must match the oldest expected access and stay stable.
    always @(negedge clk) begin
        if (mem_req && !req_seen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(1), 32'(0));
            end else begin
                cur = exp_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
                if (cur.we) chk("mem_dout", 32'(mem_dout), 32'(cur.dout));
            end
        end else if (mem_req) begin
            chk("addr_hold", 32'(mem_addr), 32'(cur.addr));
        end
        req_seen <= mem_req;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_do", 32'(do_o), 32'h0FF);
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_req", 32'(mem_req), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_dout", 32'(mem_dout), 32'(0));
        chk("rst_rdy", 32'(rdy), 32'(1));
        rst_n = 1'b1;

        // Watchdog instance: ack and expiry in the same cycle, then a real timeout
        cs_n4 = 1'b0;
        do_access(1'b1, 1'b0, 21'h00ABC, 8'h00, 4, 0, 8'h3C, rl, rc);
        chk("wd_ack_wins_do", 32'(do4), 32'h3C);
        chk("wd_ack_wins_err", 32'(err4), 32'(0));
        chk("wd_ack_wins_rdylow", 32'(rl), 32'(5));
        release_strobes();
        do_access(1'b1, 1'b0, 21'h00ABD, 8'h00, 0, 0, 8'h00, rl, rc);
        chk("to_req_cycles", 32'(rc), 32'(4));
        chk("to_do", 32'(do4), 32'h0FF);
        chk("to_err", 32'(err4), 32'(1));
        chk("to_rdy", 32'(rdy4), 32'(1));
        release_strobes();
        repeat (2) @(negedge clk);
        mem_din  = 8'h11;
        mem_ack4 = 1'b1;
        @(negedge clk);
        mem_ack4 = 1'b0;
        @(negedge clk);
        chk("to_late_ack_do", 32'(do4), 32'h0FF);
        chk("to_err_sticky", 32'(err4), 32'(1));
        cs_n4 = 1'b1;

        // Read with ack in the third REQ cycle
        cs_n = 1'b0;
        do_access(1'b0, 1'b0, 21'h12345, 8'h00, 3, 0, 8'h5A, rl, rc);
        chk("rd_rdylow", 32'(rl), 32'(4));
        chk("rd_do", 32'(do_o), 32'(exp_do));
        release_strobes();

        // Write to the top of the window; DO keeps the previous read data
        do_access(1'b0, 1'b1, 21'h1FFFFF, 8'hC3, 1, 0, 8'hEE, rl, rc);
        chk("wr_rdylow", 32'(rl), 32'(2));
        chk("wr_do_kept", 32'(do_o), 32'h5A);
        release_strobes();

        // Read->write change within one strobe is not a new access
        do_access(1'b0, 1'b0, 21'h00042, 8'h00, 2, 0, 8'h99, rl, rc);
        chk("dir_do", 32'(do_o), 32'h99);
        rd_n = 1'b1;
        wr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dir_rdy", 32'(rdy), 32'(1));
            chk("dir_noreq", 32'(mem_req), 32'(0));
        end
        release_strobes();

        // Deselected strobes are ignored
        cs_n = 1'b1;
        for (int p = 0; p < 2; p++) begin
            @(posedge clk); #1;
            rd_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("desel_rdy", 32'(rdy), 32'(1));
                chk("desel_noreq", 32'(mem_req), 32'(0));
            end
            rd_n = 1'b1;
        end
        cs_n = 1'b0;

        // CPU abort in REQ; the transaction still completes, then IDLE follows DONE
        do_access(1'b0, 1'b0, 21'h0BEEF, 8'h00, 6, 1, 8'hA7, rl, rc);
        chk("abort_rdylow", 32'(rl), 32'(7));
        chk("abort_do", 32'(do_o), 32'hA7);
        do_access(1'b0, 1'b1, 21'h00100, 8'h55, 1, 0, 8'h00, rl, rc);
        chk("after_abort_do", 32'(do_o), 32'hA7);
        release_strobes();
        repeat (2) @(negedge clk);
        mem_din = 8'h66;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_do", 32'(do_o), 32'(exp_do));
        chk("stray_ack_rdy", 32'(rdy), 32'(1));

        // Reset during REQ
        @(posedge clk); #1;
        ram_a = 21'h00777;
        rd_n  = 1'b0;
        exp_q.push_back('{1'b0, 21'h00777, 8'h00});
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!mem_req && guard < 5);
        chk("rstreq_req_seen", 32'(mem_req), 32'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstreq_req", 32'(mem_req), 32'(0));
        chk("rstreq_do", 32'(do_o), 32'h0FF);
        chk("rstreq_err", 32'(err), 32'(0));
        chk("rstreq_err4", 32'(err4), 32'(0));
        release_strobes();
        exp_do = 8'hFF;
        @(negedge clk);
        mem_din = 8'h22;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_do", 32'(do_o), 32'h0FF);
        chk("late_ack_req", 32'(mem_req), 32'(0));
        do_access(1'b0, 1'b0, 21'h00777, 8'h00, 2, 0, 8'h4D, rl, rc);
        chk("post_rst_rdylow", 32'(rl), 32'(3));
        chk("post_rst_do", 32'(do_o), 32'h4D);
        release_strobes();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
